incubator: RTL and testbench
============================

INCUBATOR -- requirements
Module: incubator

Interface
REQ-001 Parameter HEAT_ON, default 15: heating starts when sensor < HEAT_ON.
REQ-002 Parameter HEAT_OFF, default 30: heating stops when sensor > HEAT_OFF.
REQ-003 Parameter COOL_ON, default 35: cooling starts when sensor > COOL_ON.
REQ-004 Parameter COOL_OFF, default 25: cooling stops when sensor < COOL_OFF.
REQ-005 Parameter FAN_MID, default 40: escalation threshold to 6 rps; also de-escalation threshold from 8 rps.
REQ-006 Parameter FAN_HIGH, default 45: escalation threshold to 8 rps.
REQ-007 clock  input  1  the single clock of the block; all state updates on its rising edge.
REQ-008 reset  input  1  reset is synchronous and active-high.
REQ-009 sensor  input  8  temperature in degrees C, signed two's complement (-128..127).
REQ-010 cooler  output  1  cooler enable.
REQ-011 heater  output  1  heater enable.
REQ-012 rps  output  4  cooler fan speed in revolutions per second (0, 4, 6 or 8).

Function
REQ-013 Moore state machine with states IDLE, HEAT, COOL4, COOL6, COOL8; outputs decode from the state register only.
REQ-014 All comparisons are signed 8-bit and strict (< or >); a sensor value equal to a threshold causes no transition.
REQ-015 IDLE outputs: heater=0, cooler=0, rps=0.
REQ-016 HEAT outputs: heater=1, cooler=0, rps=0.
REQ-017 COOL4, COOL6 and COOL8 outputs: heater=0, cooler=1, rps=4, 6 and 8 respectively.
REQ-018 IDLE transitions: to HEAT if sensor < HEAT_ON; otherwise to COOL4 if sensor > COOL_ON; otherwise stay in IDLE.
REQ-019 HEAT transitions: to IDLE if sensor > HEAT_OFF; otherwise stay in HEAT.
REQ-020 COOL4 transitions: to IDLE if sensor < COOL_OFF; otherwise to COOL6 if sensor > FAN_MID; otherwise stay in COOL4.
REQ-021 COOL6 transitions: to COOL4 if sensor < COOL_ON; otherwise to COOL8 if sensor > FAN_HIGH; otherwise stay in COOL6.
REQ-022 COOL8 transitions: to COOL6 if sensor < FAN_MID; otherwise stay in COOL8.
REQ-023 At most one transition per clock, so fan speed steps one level per cycle in either direction, and a jump between HEAT and any COOL state always passes through IDLE.
REQ-024 Latency: sensor is sampled at a rising edge, and outputs reflect the new state immediately after that same edge, i.e. one cycle of latency.
REQ-025 heater and cooler are never 1 simultaneously; rps is 0 whenever cooler is 0.
REQ-026 Unused state encodings go to IDLE on the next clock.

Reset
REQ-027 When reset=1 at a rising edge, the state becomes IDLE (heater=0, cooler=0, rps=0), regardless of current state or sensor value.
REQ-028 Reset has priority over all transitions; asserted mid-cooling or mid-heating, it forces IDLE at that edge.
REQ-029 Outputs are undefined before the first reset edge; no asynchronous behaviour is permitted.

Verification
REQ-030 Reset with sensor=20 -> IDLE, heater=0, cooler=0, rps=0; holding 20 keeps IDLE.
REQ-031 From IDLE, sensor=-40 -> next edge heater=1; sensor=20 -> stays HEAT; sensor=30 -> stays HEAT; sensor=33 -> next edge IDLE.
REQ-032 From IDLE, sensor=46 held -> successive edges give rps=4, 6, 8 with cooler=1; then sensor=20 -> rps 6, 4, then IDLE (cooler=0) on successive edges.
REQ-033 From COOL4, sensor=25 -> stays COOL4; sensor=24 -> IDLE. From COOL6, sensor=-5 -> COOL4, then IDLE.
REQ-034 Boundaries from IDLE: sensor=15 and sensor=35 -> stay IDLE; sensor=14 -> HEAT; sensor=36 -> COOL4.
REQ-035 In COOL8, assert reset with sensor=46 -> IDLE at that edge; after release, re-escalates COOL4, COOL6, COOL8.

Source files
------------

// File: rtl/incubator.sv
// Incubator climate controller: a Moore machine that drives the heater and a
// three-speed cooler from a signed temperature reading. Hysteresis comes from
// separate on/off thresholds. The fan steps at most one speed level per clock.
module incubator #(
  parameter int HEAT_ON  = 15,
  parameter int HEAT_OFF = 30,
  parameter int COOL_ON  = 35,
  parameter int COOL_OFF = 25,
  parameter int FAN_MID  = 40,
  parameter int FAN_HIGH = 45
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] sensor,
  output logic       cooler,
  output logic       heater,
  output logic [3:0] rps
);

  // Thresholds as signed 8-bit values, so every comparison is a signed compare.
  localparam logic signed [7:0] HEAT_ON_C  = 8'(HEAT_ON);
  localparam logic signed [7:0] HEAT_OFF_C = 8'(HEAT_OFF);
  localparam logic signed [7:0] COOL_ON_C  = 8'(COOL_ON);
  localparam logic signed [7:0] COOL_OFF_C = 8'(COOL_OFF);
  localparam logic signed [7:0] FAN_MID_C  = 8'(FAN_MID);
  localparam logic signed [7:0] FAN_HIGH_C = 8'(FAN_HIGH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAT  = 3'd1,
    COOL4 = 3'd2,
    COOL6 = 3'd3,
    COOL8 = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic signed [7:0] temp_s;
  logic              heater_s;
  logic              cooler_s;
  logic [3:0]        rps_s;
  logic              heater_r;
  logic              cooler_r;
  logic [3:0]        rps_r;

  assign temp_s = $signed(sensor);

  // Next-state selection: strict thresholds, one step per clock, and any
  // unused encoding falls back to IDLE.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (temp_s < HEAT_ON_C) begin
          next_state_s = HEAT;
        end else if (temp_s > COOL_ON_C) begin
          next_state_s = COOL4;
        end else begin
          next_state_s = IDLE;
        end
      end
      HEAT: begin
        if (temp_s > HEAT_OFF_C) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HEAT;
        end
      end
      COOL4: begin
        if (temp_s < COOL_OFF_C) begin
          next_state_s = IDLE;
        end else if (temp_s > FAN_MID_C) begin
          next_state_s = COOL6;
        end else begin
          next_state_s = COOL4;
        end
      end
      COOL6: begin
        if (temp_s < COOL_ON_C) begin
          next_state_s = COOL4;
        end else if (temp_s > FAN_HIGH_C) begin
          next_state_s = COOL8;
        end else begin
          next_state_s = COOL6;
        end
      end
      COOL8: begin
        if (temp_s < FAN_MID_C) begin
          next_state_s = COOL6;
        end else begin
          next_state_s = COOL8;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode of the state about to be entered. The decode is registered
  // alongside the state, so the outputs are a pure function of the stored
  // state and come straight from flops.
  always_comb begin
    heater_s = 1'b0;
    cooler_s = 1'b0;
    rps_s    = 4'd0;
    case (next_state_s)
      HEAT: begin
        heater_s = 1'b1;
      end
      COOL4: begin
        cooler_s = 1'b1;
        rps_s    = 4'd4;
      end
      COOL6: begin
        cooler_s = 1'b1;
        rps_s    = 4'd6;
      end
      COOL8: begin
        cooler_s = 1'b1;
        rps_s    = 4'd8;
      end
      default: begin
        heater_s = 1'b0;
        cooler_s = 1'b0;
        rps_s    = 4'd0;
      end
    endcase
  end

  // State and output registers. Synchronous reset has priority and forces IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      heater_r <= 1'b0;
      cooler_r <= 1'b0;
      rps_r    <= 4'd0;
    end else begin
      state_r  <= next_state_s;
      heater_r <= heater_s;
      cooler_r <= cooler_s;
      rps_r    <= rps_s;
    end
  end

  assign heater = heater_r;
  assign cooler = cooler_r;
  assign rps    = rps_r;

endmodule

// File: tb/tb_incubator.sv
// Directed bench for the incubator controller. A level-based behavioural
// model is checked against the DUT on every falling edge, and literal
// expectations are checked after each rising edge.
module tb_incubator;

  logic       clock;
  logic       reset;
  logic [7:0] sensor;
  logic       cooler;
  logic       heater;
  logic [3:0] rps;

  int checks = 0;
  int errors = 0;

  incubator dut (
    .clock  (clock),
    .reset  (reset),
    .sensor (sensor),
    .cooler (cooler),
    .heater (heater),
    .rps    (rps)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: the climate is a single level. -1 is heating, 0 is idle, and 1..3
  // are cooling with the fan at 4, 6 or 8 rps.
  int model_lvl   = 0;
  bit model_valid = 1'b0;
  int up_th [0:2];
  int dn_th [1:3];

  initial begin
    up_th[0] = 35; up_th[1] = 40; up_th[2] = 45;   // COOL_ON, FAN_MID, FAN_HIGH
    dn_th[1] = 25; dn_th[2] = 35; dn_th[3] = 40;   // COOL_OFF, COOL_ON, FAN_MID
  end

  // Advance the model on each rising edge.
  always @(posedge clock) begin
    int s;
    s = int'($signed(sensor));
    if (reset) begin
      model_lvl   <= 0;
      model_valid <= 1'b1;
    end else if (model_lvl < 0) begin
      if (s > 30) model_lvl <= 0;
    end else if (model_lvl == 0) begin
      if (s < 15) model_lvl <= -1;
      else if (s > up_th[0]) model_lvl <= 1;
    end else begin
      if (s < dn_th[model_lvl]) model_lvl <= model_lvl - 1;
      else if (model_lvl < 3 && s > up_th[model_lvl]) model_lvl <= model_lvl + 1;
    end
  end

  // Compare the DUT with the model on every falling edge after the first reset.
  always @(negedge clock) begin
    logic       eh;
    logic       ec;
    logic [3:0] er;
    if (model_valid) begin
      eh = (model_lvl < 0);
      ec = (model_lvl > 0);
      er = (model_lvl > 0) ? 4'(2 + 2 * model_lvl) : 4'd0;
      checks++;
      if (heater !== eh || cooler !== ec || rps !== er) begin
        errors++;
        $display("FAIL model_cmp t=%0t got h=%b c=%b rps=%0d want h=%b c=%b rps=%0d",
                 $time, heater, cooler, rps, eh, ec, er);
      end
    end
  end

  // Apply one sensor value and reset level for one rising edge, then compare
  // the outputs with literal expectations just after that edge.
  task automatic step(input string name, input int s, input logic r,
                      input logic eh, input logic ec, input int er);
    sensor = 8'(s);
    reset  = r;
    @(posedge clock);
    #1;
    checks++;
    if (heater !== eh || cooler !== ec || rps !== 4'(er)) begin
      errors++;
      $display("FAIL %s got h=%b c=%b rps=%0d want h=%b c=%b rps=%0d",
               name, heater, cooler, rps, eh, ec, er);
    end
  endtask

  initial begin
    reset  = 1'b0;
    sensor = 8'd20;
    @(negedge clock);
    // Reset and idle hold
    step("rst_idle",   20, 1'b1, 1'b0, 1'b0, 0);
    step("idle_hold1", 20, 1'b0, 1'b0, 1'b0, 0);
    step("idle_hold2", 20, 1'b0, 1'b0, 1'b0, 0);
    // Heating cycle
    step("heat_on",   -40, 1'b0, 1'b1, 1'b0, 0);
    step("heat_20",    20, 1'b0, 1'b1, 1'b0, 0);
    step("heat_30",    30, 1'b0, 1'b1, 1'b0, 0);
    step("heat_off",   33, 1'b0, 1'b0, 1'b0, 0);
    // Escalation and de-escalation
    step("esc4",       46, 1'b0, 1'b0, 1'b1, 4);
    step("esc6",       46, 1'b0, 1'b0, 1'b1, 6);
    step("esc8",       46, 1'b0, 1'b0, 1'b1, 8);
    step("desc6",      20, 1'b0, 1'b0, 1'b1, 6);
    step("desc4",      20, 1'b0, 1'b0, 1'b1, 4);
    step("desc_idle",  20, 1'b0, 1'b0, 1'b0, 0);
    // COOL4 off boundary
    step("c4_enter",   36, 1'b0, 1'b0, 1'b1, 4);
    step("c4_25",      25, 1'b0, 1'b0, 1'b1, 4);
    step("c4_24",      24, 1'b0, 1'b0, 1'b0, 0);
    // COOL6 drop with a cold reading
    step("c6_a",       46, 1'b0, 1'b0, 1'b1, 4);
    step("c6_b",       46, 1'b0, 1'b0, 1'b1, 6);
    step("c6_neg5",    -5, 1'b0, 1'b0, 1'b1, 4);
    step("c4_neg5",    -5, 1'b0, 1'b0, 1'b0, 0);
    // Idle boundaries
    step("idle_15",    15, 1'b0, 1'b0, 1'b0, 0);
    step("idle_35",    35, 1'b0, 1'b0, 1'b0, 0);
    step("idle_14",    14, 1'b0, 1'b1, 1'b0, 0);
    step("heat_31",    31, 1'b0, 1'b0, 1'b0, 0);
    step("idle_36",    36, 1'b0, 1'b0, 1'b1, 4);
    // Fan boundaries in each direction
    step("c4_40",      40, 1'b0, 1'b0, 1'b1, 4);
    step("c4_41",      41, 1'b0, 1'b0, 1'b1, 6);
    step("c6_45",      45, 1'b0, 1'b0, 1'b1, 6);
    step("c6_46",      46, 1'b0, 1'b0, 1'b1, 8);
    step("c8_40",      40, 1'b0, 1'b0, 1'b1, 8);
    step("c8_39",      39, 1'b0, 1'b0, 1'b1, 6);
    step("c6_35",      35, 1'b0, 1'b0, 1'b1, 6);
    step("c6_34",      34, 1'b0, 1'b0, 1'b1, 4);
    step("c4_drop",    24, 1'b0, 1'b0, 1'b0, 0);
    // Reset in COOL8, then re-escalation
    step("r_c4",       46, 1'b0, 1'b0, 1'b1, 4);
    step("r_c6",       46, 1'b0, 1'b0, 1'b1, 6);
    step("r_c8",       46, 1'b0, 1'b0, 1'b1, 8);
    step("rst_c8",     46, 1'b1, 1'b0, 1'b0, 0);
    step("re_c4",      46, 1'b0, 1'b0, 1'b1, 4);
    step("re_c6",      46, 1'b0, 1'b0, 1'b1, 6);
    step("re_c8",      46, 1'b0, 1'b0, 1'b1, 8);
    step("rst_c8b",    46, 1'b1, 1'b0, 1'b0, 0);
    // Signed extremes and reset during heating
    step("min_heat", -128, 1'b0, 1'b1, 1'b0, 0);
    step("rst_heat",    0, 1'b1, 1'b0, 1'b0, 0);
    step("max_cool",  127, 1'b0, 1'b0, 1'b1, 4);
    step("idle_rst",  127, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
